inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have these ports, one clock domain:
 clk  in  1  rising-edge clock
 rst  in  1  asynchronous, active-low reset (0 = reset)
 pc  in  32  fetch address from PC register
 stall  in  1  hold IF/ID register (from pipeline controller)
 flush  in  1  discard in-flight fetch, clear IF/ID
 inst_req  out  1  instruction-memory request, held until ack
 inst_addr  out  32  request address, stable while inst_req=1
 inst_ack  in  1  one-cycle response strobe
 inst_rdata  in  32  instruction, valid with inst_ack
 stallreq_if  out  1  request to controller to freeze PC/IF
 id_pc  out  32  IF/ID PC
 id_inst  out  32  IF/ID instruction
 id_valid  out  1  IF/ID contents valid
 id_excepttype  out  32  IF/ID exception vector

Function
REQ-002 FSM states SHALL be IDLE, FETCH, DISCARD, HOLD; reset state IDLE.
REQ-003 IDLE, stall=0, flush=0, pc[1:0]=00: latch pc into req_addr, assert inst_req next cycle, go FETCH.
REQ-004 IDLE, pc[1:0]!=00, stall=0: no request; IF/ID load id_pc=pc, id_inst=0, id_valid=1, id_excepttype bit EXC_ADEL_IF=1, all other bits 0.
REQ-005 FETCH: inst_req=1, inst_addr=req_addr; stallreq_if=1 until the inst_ack cycle.
REQ-006 FETCH, inst_ack=1, flush=0, stall=0: next edge load id_pc=req_addr, id_inst=inst_rdata, id_valid=1, id_excepttype=0; drop inst_req; go IDLE.
REQ-007 FETCH, inst_ack=1, stall=1: capture rdata/addr into one-entry hold buffer, go HOLD; IF/ID unchanged.
REQ-008 HOLD: no request; stallreq_if=0; on first cycle stall=0, load IF/ID from buffer, go IDLE.
REQ-009 FETCH, flush=1, inst_ack=0: go DISCARD; inst_req stays 1 with same inst_addr (requests never retracted).
REQ-010 DISCARD: stallreq_if=1; on inst_ack drop data, drop inst_req, go IDLE; IF/ID stays cleared.
REQ-011 flush=1 in any state SHALL clear IF/ID (id_pc=0, id_inst=0, id_valid=0, id_excepttype=0) at next edge and empty hold buffer; flush has priority over stall and ack.
REQ-012 flush=1 with inst_ack=1 same cycle SHALL drop the response and go IDLE.
REQ-013 stall=1 with no pending data SHALL hold IF/ID unchanged; IDLE SHALL NOT issue.
REQ-014 Fetch latency SHALL be: req asserted cycle N+1 after IDLE sample at N; IF/ID updated edge after ack.
REQ-015 Back-to-back fetches SHALL have at most one IDLE cycle between ack and next request.
REQ-016 Only one request outstanding at any time.

Reset
REQ-017 rst=0 asynchronously forces: state IDLE, inst_req=0, inst_addr=0, stallreq_if=0, id_pc=0, id_inst=0, id_valid=0, id_excepttype=0, hold buffer empty.
REQ-018 Reset mid-FETCH SHALL abandon the request; memory side tolerates a late ack, which IDLE ignores.
REQ-019 First request no earlier than second rising clk edge after rst rises.

Structure
REQ-020 Shared package holds: state encoding, EXC_ADEL_IF (=13), 32-bit bus widths, NOP value 32'h0.
REQ-021 One sub-module if_id_reg (IF/ID register with stall/flush/load) SHALL be instantiated; FSM and hold buffer stay in inst_fetch.

Verification
REQ-022 pc=0x00000100, ack 2 cycles after req, rdata=0x24020005 -> id_pc=0x100, id_inst=0x24020005, id_valid=1; stallreq_if high exactly 2 cycles.
REQ-023 pc=0x00000102 -> no inst_req; id_excepttype=0x00002000, id_inst=0, id_pc=0x102.
REQ-024 stall=1 during ack of pc=0x200 (rdata 0x8C430000), released 3 cycles later -> IF/ID unchanged until release, then id_inst=0x8C430000, id_pc=0x200.
REQ-025 flush cycle after req for pc=0x300, ack 3 cycles later -> inst_req held with inst_addr=0x300 until ack, IF/ID cleared, no id_valid=1 from that fetch.
REQ-026 flush and ack same cycle -> response dropped, id_valid=0, state IDLE.
REQ-027 rst=0 asynchronously mid-FETCH -> all outputs 0 immediately; late ack after release ignored.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, bus widths,
// exception bit positions and the IF/ID payload struct.
package inst_fetch_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int EXC_W  = 32;

    localparam int EXC_ADEL_IF = 13;
    localparam logic [EXC_W-1:0]  EXC_ADEL_IF_VEC = EXC_W'(1) << EXC_ADEL_IF;
    localparam logic [DATA_W-1:0] NOP = 32'h0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2,
        S_HOLD    = 2'd3
    } if_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
        logic [EXC_W-1:0]  exc;
    } ifid_t;

    function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register: flush clears it, load writes it unless stalled,
// otherwise contents are held.
module if_id_reg
    import inst_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              load,
    input  ifid_t             din,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    output logic              id_valid,
    output logic [EXC_W-1:0]  id_excepttype
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc         <= '0;
            id_inst       <= NOP;
            id_valid      <= 1'b0;
            id_excepttype <= '0;
        end else if (flush) begin
            id_pc         <= '0;
            id_inst       <= NOP;
            id_valid      <= 1'b0;
            id_excepttype <= '0;
        end else if (load && !stall) begin
            id_pc         <= din.pc;
            id_inst       <= din.inst;
            id_valid      <= 1'b1;
            id_excepttype <= din.exc;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one memory request at a time, parks a
// response in a one-entry buffer while the pipeline is stalled, and feeds IF/ID.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    input  logic              flush,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_ack,
    input  logic [DATA_W-1:0] inst_rdata,
    output logic              stallreq_if,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    output logic              id_valid,
    output logic [EXC_W-1:0]  id_excepttype
);

    if_state_t         state, state_next;
    logic              armed;
    logic [ADDR_W-1:0] req_addr, req_addr_next;
    logic              buf_valid, buf_valid_next;
    logic [ADDR_W-1:0] buf_pc, buf_pc_next;
    logic [DATA_W-1:0] buf_inst, buf_inst_next;
    logic              ld;
    ifid_t             ld_data;

    // armed stays low for the first edge after reset so no request goes out on it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            armed     <= 1'b0;
            req_addr  <= '0;
            buf_valid <= 1'b0;
            buf_pc    <= '0;
            buf_inst  <= NOP;
        end else begin
            state     <= state_next;
            armed     <= 1'b1;
            req_addr  <= req_addr_next;
            buf_valid <= buf_valid_next;
            buf_pc    <= buf_pc_next;
            buf_inst  <= buf_inst_next;
        end
    end

    always_comb begin
        state_next     = state;
        req_addr_next  = req_addr;
        buf_valid_next = buf_valid;
        buf_pc_next    = buf_pc;
        buf_inst_next  = buf_inst;
        ld             = 1'b0;
        ld_data        = '0;

        unique case (state)
            S_IDLE: begin
                if (!flush && !stall && armed) begin
                    if (is_aligned(pc)) begin
                        req_addr_next = pc;
                        state_next    = S_FETCH;
                    end else begin
                        ld           = 1'b1;
                        ld_data.pc   = pc;
                        ld_data.inst = NOP;
                        ld_data.exc  = EXC_ADEL_IF_VEC;
                    end
                end
            end
            S_FETCH: begin
                // a flushed request stays on the bus until memory answers it
                if (flush) begin
                    state_next = inst_ack ? S_IDLE : S_DISCARD;
                end else if (inst_ack) begin
                    if (stall) begin
                        buf_valid_next = 1'b1;
                        buf_pc_next    = req_addr;
                        buf_inst_next  = inst_rdata;
                        state_next     = S_HOLD;
                    end else begin
                        ld           = 1'b1;
                        ld_data.pc   = req_addr;
                        ld_data.inst = inst_rdata;
                        ld_data.exc  = '0;
                        state_next   = S_IDLE;
                    end
                end
            end
            S_DISCARD: begin
                if (inst_ack) begin
                    state_next = S_IDLE;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_next = S_IDLE;
                end else if (!stall) begin
                    ld             = buf_valid;
                    ld_data.pc     = buf_pc;
                    ld_data.inst   = buf_inst;
                    ld_data.exc    = '0;
                    buf_valid_next = 1'b0;
                    state_next     = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (flush) begin
            buf_valid_next = 1'b0;
        end
    end

    assign inst_req    = (state == S_FETCH) || (state == S_DISCARD);
    assign inst_addr   = req_addr;
    assign stallreq_if = ((state == S_FETCH) && !inst_ack) || (state == S_DISCARD);

    if_id_reg u_if_id_reg (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .stall         (stall),
        .load          (ld),
        .din           (ld_data),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_valid      (id_valid),
        .id_excepttype (id_excepttype)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios followed by random traffic, all
// checked against a transaction-level reference model.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;
    logic        stallreq_if;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic [31:0] id_excepttype;

    inst_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .stall         (stall),
        .flush         (flush),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_ack      (inst_ack),
        .inst_rdata    (inst_rdata),
        .stallreq_if   (stallreq_if),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_valid      (id_valid),
        .id_excepttype (id_excepttype)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: outstanding request, parked response, expected IF/ID.
    logic        m_armed;
    logic        m_out_valid;
    logic        m_out_killed;
    logic [31:0] m_out_addr;
    logic        m_hold_valid;
    logic [31:0] m_hold_pc;
    logic [31:0] m_hold_inst;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_valid;
    logic [31:0] e_exc;

    logic        last_req;
    logic [31:0] last_addr;
    int          sr_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_armed      = 1'b0;
        m_out_valid  = 1'b0;
        m_out_killed = 1'b0;
        m_out_addr   = 32'h0;
        m_hold_valid = 1'b0;
        m_hold_pc    = 32'h0;
        m_hold_inst  = 32'h0;
        e_pc         = 32'h0;
        e_inst       = 32'h0;
        e_valid      = 1'b0;
        e_exc        = 32'h0;
    endtask

    task automatic deliver(input logic [31:0] p, input logic [31:0] i, input logic [31:0] x);
        e_pc    = p;
        e_inst  = i;
        e_exc   = x;
        e_valid = 1'b1;
    endtask

    task automatic model_step(input logic [31:0] p, input logic s, input logic f,
                              input logic a, input logic [31:0] d);
        if (f) begin
            e_pc = 32'h0; e_inst = 32'h0; e_exc = 32'h0; e_valid = 1'b0;
            m_hold_valid = 1'b0;
            if (m_out_valid) begin
                if (a) m_out_valid = 1'b0;
                else   m_out_killed = 1'b1;
            end
        end else if (m_out_valid) begin
            if (a) begin
                m_out_valid = 1'b0;
                if (!m_out_killed) begin
                    if (s) begin
                        m_hold_valid = 1'b1;
                        m_hold_pc    = m_out_addr;
                        m_hold_inst  = d;
                    end else begin
                        deliver(m_out_addr, d, 32'h0);
                    end
                end
            end
        end else if (m_hold_valid) begin
            if (!s) begin
                deliver(m_hold_pc, m_hold_inst, 32'h0);
                m_hold_valid = 1'b0;
            end
        end else if (m_armed && !s) begin
            if (p % 4 == 0) begin
                m_out_valid  = 1'b1;
                m_out_addr   = p;
                m_out_killed = 1'b0;
            end else begin
                deliver(p, 32'h0, 32'h0000_2000);
            end
        end
        m_armed = 1'b1;
    endtask

    // Entered 1 time unit after a rising edge; leaves 1 time unit after the next.
    task automatic cycle(input logic [31:0] p, input logic s, input logic f,
                         input logic a, input logic [31:0] d);
        pc = p; stall = s; flush = f; inst_ack = a; inst_rdata = d;
        #1;
        last_req  = inst_req;
        last_addr = inst_addr;
        if (stallreq_if) sr_cnt++;
        check("inst_req", 32'(inst_req), 32'(m_out_valid));
        if (m_out_valid) check("inst_addr", inst_addr, m_out_addr);
        check("stallreq_if", 32'(stallreq_if), 32'(m_out_valid && (m_out_killed || !a)));
        @(posedge clk);
        #1;
        model_step(p, s, f, a, d);
        check("id_pc", id_pc, e_pc);
        check("id_inst", id_inst, e_inst);
        check("id_valid", 32'(id_valid), 32'(e_valid));
        check("id_excepttype", id_excepttype, e_exc);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_inst_req"}, 32'(inst_req), 32'h0);
        check({tag, "_inst_addr"}, inst_addr, 32'h0);
        check({tag, "_stallreq_if"}, 32'(stallreq_if), 32'h0);
        check({tag, "_id_pc"}, id_pc, 32'h0);
        check({tag, "_id_inst"}, id_inst, 32'h0);
        check({tag, "_id_valid"}, 32'(id_valid), 32'h0);
        check({tag, "_id_excepttype"}, id_excepttype, 32'h0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] rp;
        logic [1:0]  lo;
        logic        rs, rf, ra;

        rst = 1'b0; pc = 32'h0; stall = 1'b0; flush = 1'b0;
        inst_ack = 1'b0; inst_rdata = 32'h0; sr_cnt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        // Aligned fetch, ack two cycles after the request
        sr_cnt = 0;
        cycle(32'h100, 0, 0, 0, 32'h0);
        check("no_req_first_edge", 32'(last_req), 32'h0);
        cycle(32'h100, 0, 0, 0, 32'h0);
        check("no_req_second_cycle", 32'(last_req), 32'h0);
        cycle(32'h100, 0, 0, 0, 32'h0);
        check("req_after_idle", 32'(last_req), 32'h1);
        cycle(32'h100, 0, 0, 0, 32'h0);
        cycle(32'h100, 0, 0, 1, 32'h2402_0005);
        check("fetch_id_pc", id_pc, 32'h100);
        check("fetch_id_inst", id_inst, 32'h2402_0005);
        check("fetch_id_valid", 32'(id_valid), 32'h1);
        check("stallreq_cycles", 32'(sr_cnt), 32'h2);

        // Misaligned pc raises the address-error exception without a request
        cycle(32'h102, 0, 0, 0, 32'h0);
        check("misalign_no_req", 32'(last_req), 32'h0);
        check("misalign_exc", id_excepttype, 32'h0000_2000);
        check("misalign_inst", id_inst, 32'h0);
        check("misalign_pc", id_pc, 32'h102);

        // Stall across the ack parks the response until release
        cycle(32'h200, 0, 0, 0, 32'h0);
        cycle(32'h200, 0, 0, 0, 32'h0);
        cycle(32'h200, 1, 0, 1, 32'h8C43_0000);
        check("hold_unchanged_pc", id_pc, 32'h102);
        cycle(32'h200, 1, 0, 0, 32'h0);
        cycle(32'h200, 1, 0, 0, 32'h0);
        check("hold_unchanged_exc", id_excepttype, 32'h0000_2000);
        cycle(32'h300, 0, 0, 0, 32'h0);
        check("hold_release_inst", id_inst, 32'h8C43_0000);
        check("hold_release_pc", id_pc, 32'h200);

        // Flush the cycle after the request; request stays up until the late ack
        cycle(32'h300, 0, 0, 0, 32'h0);
        cycle(32'h300, 0, 0, 0, 32'h0);
        cycle(32'h300, 0, 1, 0, 32'h0);
        check("flush_clears_valid", 32'(id_valid), 32'h0);
        cycle(32'h300, 0, 0, 0, 32'h0);
        check("discard_req_held", 32'(last_req), 32'h1);
        check("discard_addr_held", last_addr, 32'h300);
        cycle(32'h300, 0, 0, 0, 32'h0);
        cycle(32'h300, 0, 0, 1, 32'hDEAD_BEEF);
        check("discard_addr_at_ack", last_addr, 32'h300);
        check("discard_no_valid", 32'(id_valid), 32'h0);
        check("discard_no_inst", id_inst, 32'h0);

        // Flush and ack in the same cycle
        cycle(32'h3F0, 0, 0, 0, 32'h0);
        cycle(32'h3F0, 0, 0, 1, 32'hAAAA_0001);
        check("pre_flush_valid", 32'(id_valid), 32'h1);
        cycle(32'h400, 0, 0, 0, 32'h0);
        cycle(32'h400, 0, 1, 1, 32'h1111_1111);
        check("flush_ack_valid", 32'(id_valid), 32'h0);
        check("flush_ack_state", 32'(dut.state), 32'(S_IDLE));
        cycle(32'h400, 1, 0, 0, 32'h0);
        check("flush_ack_no_req", 32'(last_req), 32'h0);

        // Asynchronous reset in the middle of a fetch, then a late ack
        cycle(32'h480, 0, 0, 0, 32'h0);
        cycle(32'h480, 0, 0, 1, 32'hCAFE_F00D);
        cycle(32'h500, 0, 0, 0, 32'h0);
        cycle(32'h500, 0, 0, 0, 32'h0);
        check("pre_reset_req", 32'(last_req), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        check("async_reset_state", 32'(dut.state), 32'(S_IDLE));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(32'h500, 1, 0, 1, 32'h9999_9999);
        check("late_ack_ignored", 32'(id_valid), 32'h0);
        cycle(32'h500, 0, 0, 0, 32'h0);
        cycle(32'h500, 0, 0, 1, 32'h1234_5678);
        check("after_reset_fetch", id_inst, 32'h1234_5678);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom();
            lo = 2'($urandom_range(1, 3));
            rp = ($urandom_range(0, 7) == 0) ? {r[31:2], lo} : {r[31:2], 2'b00};
            rs = ($urandom_range(0, 3) == 0);
            rf = ($urandom_range(0, 11) == 0);
            ra = m_out_valid && ($urandom_range(0, 2) == 0);
            cycle(rp, rs, rf, ra, $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
